// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game: round FSM and scorer state encodings,
// plus the reaction-delay LFSR constants and helpers.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_RELEASE = 3'd0,
    ST_DELAY   = 3'd1,
    ST_LIGHT   = 3'd2,
    ST_POINT   = 3'd3,
    ST_HALT    = 3'd4
  } rc_state_e;

  // Scorer stage encoding, kept here so both stages agree on one package.
  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_SHIFT = 2'd1,
    SC_WIN   = 2'd2
  } score_state_e;

  localparam int         CNT_W     = 17;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;  // bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic state_legal(input rc_state_e s);
    return s inside {ST_RELEASE, ST_DELAY, ST_LIGHT, ST_POINT, ST_HALT};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR supplying the random part of the lights-off delay.
module lfsr8
  import tow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/round_ctrl.sv
// Reaction-round controller: random lights-off delay, lights-on window, and
// registered decision of which synchronized push button came first.
module round_ctrl
  import tow_pkg::*;
#(
  parameter int DELAY_MIN = 16,
  parameter int SHIFT     = 4,
  parameter int LIGHT_MAX = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  input  logic done,
  output logic leds_on,
  output logic winrnd,
  output logic right,
  output logic tie
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIGHT_CNT = CNT_W'(LIGHT_MAX);
  localparam logic [CNT_W-1:0] DMIN_CNT  = CNT_W'(DELAY_MIN);

  logic [1:0]       meta_q;
  logic [1:0]       sync_q;
  logic             s_l;
  logic             s_r;
  logic             push;

  logic [7:0]       lfsr;
  logic [CNT_W-1:0] delay_load;

  rc_state_e        state_q;
  rc_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             leds_q, leds_d;
  logic             winrnd_q, winrnd_d;
  logic             right_q, right_d;
  logic             tie_q, tie_d;

  // Bit 0 carries the left button, bit 1 the right button.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {pbr, pbl};
      sync_q <= meta_q;
    end
  end

  assign s_l  = sync_q[0];
  assign s_r  = sync_q[1];
  assign push = s_l | s_r;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign delay_load = DMIN_CNT + (CNT_W'(lfsr) << SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RELEASE;
      cnt_q    <= '0;
      leds_q   <= 1'b0;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      leds_q   <= leds_d;
      winrnd_q <= winrnd_d;
      right_q  <= right_d;
      tie_q    <= tie_d;
    end
  end

  // A push has priority over the counter expiring in both DELAY and LIGHT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASE: begin
        if (!push) begin
          state_d = ST_DELAY;
          cnt_d   = delay_load;
        end
      end
      ST_DELAY: begin
        if (push) begin
          state_d = ST_POINT;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_LIGHT;
          cnt_d   = LIGHT_CNT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_LIGHT: begin
        if (push) begin
          state_d = ST_POINT;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_POINT: begin
        state_d = ST_RELEASE;
      end
      ST_HALT: begin
        if (!done) begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
    endcase
    if (done) begin
      state_d = ST_HALT;
    end
  end

  // Outputs are decided from the next state so they line up with it after the edge.
  always_comb begin
    leds_d   = 1'b0;
    winrnd_d = 1'b0;
    right_d  = right_q;
    tie_d    = tie_q;
    case (state_d)
      ST_LIGHT: begin
        leds_d = 1'b1;
      end
      ST_POINT: begin
        winrnd_d = 1'b1;
        leds_d   = (state_q == ST_LIGHT);
        right_d  = s_r & ~s_l;
        tie_d    = s_l & s_r;
      end
      default: begin
      end
    endcase
    if (!state_legal(state_q)) begin
      right_d = 1'b0;
      tie_d   = 1'b0;
    end
  end

  assign leds_on = leds_q;
  assign winrnd  = winrnd_q;
  assign right   = right_q;
  assign tie     = tie_q;

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter DELAY_MIN, default 16, minimum lights-off delay in clk cycles (1..255).
REQ-002 Parameter SHIFT, default 4, left-shift applied to the random term of the delay (0..7).
REQ-003 Parameter LIGHT_MAX, default 200, maximum lights-on window in clk cycles (1..65535).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 pbl  input  1  left push button, raw and asynchronous.
REQ-007 pbr  input  1  right push button, raw and asynchronous.
REQ-008 done  input  1  game over, driven high by the score stage when score is a win pattern.
REQ-009 leds_on  output  1  round lights; also qualifies the push reported on winrnd.
REQ-010 winrnd  output  1  one-cycle pulse: a push has been decided.
REQ-011 right  output  1  1 = right pushed first; valid while winrnd=1.
REQ-012 tie  output  1  both pushed in the same synchronized cycle; valid while winrnd=1.

Function
REQ-013 pbl and pbr SHALL each pass through a 2-flop synchronizer, giving s_l and s_r; all decisions use only s_l and s_r.
REQ-014 An 8-bit LFSR SHALL advance every cycle: next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
REQ-015 The FSM SHALL have the states RELEASE, DELAY, LIGHT, POINT and HALT.
REQ-016 RELEASE: leds_on=0 and pushes are ignored; when s_l=s_r=0, go to DELAY and load cnt = DELAY_MIN + (lfsr << SHIFT), using the current lfsr value.
REQ-017 DELAY: leds_on=0; cnt decrements each cycle; on the cycle cnt reaches 1, go to LIGHT and load cnt = LIGHT_MAX; DELAY lasts exactly the loaded count in cycles.
REQ-018 DELAY with s_l|s_r=1 (jump-the-light): go to POINT with right=s_r&~s_l, tie=s_l&s_r, leds_on=0.
REQ-019 LIGHT: leds_on=1; with s_l|s_r=1, go to POINT with right=s_r&~s_l, tie=s_l&s_r, leds_on held at 1.
REQ-020 LIGHT with no push for LIGHT_MAX cycles: go to RELEASE, leds_on=0, no winrnd.
REQ-021 POINT: exactly one cycle; winrnd=1; right, tie and leds_on are stable for the whole cycle; then go to RELEASE.
REQ-022 All outputs SHALL be registered; winrnd asserts in the cycle after the s_l/s_r sample that decided it, which is 3 clk edges after pbl/pbr is first sampled high.
REQ-023 right and tie SHALL hold their last value outside POINT; they are meaningful only when winrnd=1.
REQ-024 done=1 in any state SHALL force HALT on the next edge (leds_on=0, winrnd=0); a decision pending in that cycle is dropped.
REQ-025 HALT SHALL stay in HALT while done=1, then go to RELEASE.
REQ-026 The counter SHALL be 17 bits wide so that DELAY_MIN + (255 << 7) does not overflow.
REQ-027 Unused state encodings SHALL recover to RELEASE on the next edge with all outputs 0.

Reset
REQ-028 rst=1 at a clock edge SHALL set: state=RELEASE, leds_on=0, winrnd=0, right=0, tie=0, cnt=0, lfsr=8'h01, synchronizer flops=0.
REQ-029 rst SHALL override all other inputs, including mid-round and during a POINT cycle.

Structure
REQ-030 The shared package tow_pkg SHALL hold the FSM state encoding and the LFSR tap constant; it is alongside the scorer state constants.
REQ-031 The LFSR SHALL be a sub-module, lfsr8 (ports clk, rst, q[7:0]); synchronizers and the FSM SHALL stay inline.

Verification (DELAY_MIN=4, SHIFT=0, LIGHT_MAX=8)
REQ-032 Reset release, buttons idle -> 1 RELEASE cycle plus 5 DELAY cycles (cnt=4+1), then leds_on=1 on the 6th edge after rst deasserts.
REQ-033 pbr high 2 cycles after leds_on rises -> winrnd=1 for exactly 1 cycle, with right=1, tie=0, leds_on=1; then leds_on=0.
REQ-034 pbl high during DELAY -> winrnd=1, right=0, leds_on=0; the round restarts only after pbl is released.
REQ-035 pbl and pbr rise on the same edge during LIGHT -> winrnd=1, tie=1, right=0.
REQ-036 No push in LIGHT -> leds_on drops after 8 cycles with no winrnd; a button held through the next RELEASE produces no winrnd.
REQ-037 done asserted during LIGHT -> leds_on=0 next cycle with no winrnd; done deasserted -> a new DELAY begins.
